high_to_low_delay_ctrl: RTL
===========================

Name: high_to_low_delay_ctrl

Overview:
- Falling-edge (high-to-low) delay measurement controller for the path-delay sensor; the complement of the existing low-to-high controller.
- Precharges the path under test to 1, launches a 1->0 transition on pathInput, counts clk cycles until pathResult is sampled low, then holds the count and asserts fin.
- Sits beside the rising-edge controller; both share the same path under test and the same result register interface (ld_reg).

Parameters:
CNT_W, 8, width of delay_count.
SETTLE_CYCLES, 4, consecutive cycles pathResult must be sampled 1 in PRECHARGE before launch; legal range 1..255.
TIMEOUT_CYCLES, 200, MEASURE or PRECHARGE cycle limit before abort; must be <= 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request; accepted in IDLE, DONE and ERR, ignored otherwise.
pathResult  input  1  output of path under test, sampled directly on posedge clk, no synchroniser.
pathInput  output  1  drive into path under test.
ld_reg  output  1  high while measuring; enables the external delay register.
fin  output  1  measurement complete, count valid.
timeout  output  1  measurement aborted.
delay_count  output  CNT_W  measured delay in clk cycles.

Behaviour:
- States: IDLE, PRECHARGE, MEASURE, DONE, ERR. Encoding is free; all outputs are registered or decoded from state only (no pathResult->output combinational path).
- Reset (async, rst_n=0): state=IDLE, pathInput=0, ld_reg=0, fin=0, timeout=0, delay_count=0, settle and timeout counters=0. Release is synchronous to the next posedge.
- IDLE: pathInput=0. start=1 -> PRECHARGE; settle_cnt, tmo_cnt and delay_count cleared.
- PRECHARGE: pathInput=1, ld_reg=0.
  - Each cycle with pathResult=1 increments settle_cnt; any cycle with pathResult=0 resets it to 0.
  - tmo_cnt increments every cycle.
  - When settle_cnt reaches SETTLE_CYCLES -> MEASURE on the following edge.
  - Otherwise, when tmo_cnt reaches TIMEOUT_CYCLES -> ERR.
  - The settle condition wins if both happen in the same cycle.
- MEASURE: pathInput=0 (launch edge is the first MEASURE cycle), ld_reg=1; tmo_cnt cleared on entry.
  - pathResult=1 sampled: delay_count += 1.
  - pathResult=0 sampled: -> DONE; delay_count not incremented that cycle.
  - If delay_count reaches TIMEOUT_CYCLES with pathResult still 1: -> ERR, delay_count holds TIMEOUT_CYCLES.
  - delay_count never wraps.
- DONE: fin=1, pathInput=0, ld_reg=0, delay_count frozen. Remains until start.
- ERR: timeout=1, pathInput=0, ld_reg=0, delay_count frozen. Remains until start.
- start in DONE/ERR: same action as in IDLE, i.e. go to PRECHARGE with counters cleared. fin and timeout drop on that same edge.
- start in PRECHARGE/MEASURE is ignored; no restart mid-measurement.
- A path already low at launch (pathResult=0 in the first MEASURE cycle) gives delay_count=0, fin.
- rst_n asserted mid-operation: immediate return to reset values, pathInput released to 0.
- fin and timeout are mutually exclusive; ld_reg=1 only in MEASURE.

Test Plan:
- Reset mid-MEASURE (rst_n low after 3 counting cycles) -> all outputs 0 immediately (async), state IDLE; a fresh start then measures correctly.
- start pulse; model holds pathResult=1 from the first PRECHARGE cycle and drops it 5 cycles after the pathInput 1->0 edge, SETTLE_CYCLES=4 -> PRECHARGE lasts exactly 4 cycles, ld_reg high 6 cycles, delay_count=5, fin=1 the cycle after pathResult is sampled 0, pathInput=0.
- PRECHARGE with pathResult toggling 1,1,0,1,1,1,1 -> settle_cnt restarts at the 0, launch occurs only after four consecutive 1s.
- pathResult stuck 0 during PRECHARGE, TIMEOUT_CYCLES=200 -> ERR after 200 cycles, timeout=1, fin=0, ld_reg never asserted.
- pathResult stuck 1 after launch -> delay_count saturates at 200, timeout=1, pathInput=0. Then start with a 3-cycle model delay -> timeout clears, fin=1, delay_count=3.
- pathResult drops in the launch cycle -> delay_count=0, fin=1. A start pulse issued during MEASURE of another run has no effect on the count.

Source files
------------

// File: rtl/high_to_low_delay_ctrl.sv
// high_to_low_delay_ctrl
// Falling-edge path-delay measurement controller. Precharges the path under
// test to 1, launches a 1->0 edge on pathInput and counts clk cycles until
// pathResult is sampled low. The count is then held and fin is raised.
// Precharge or measurement overruns abort with timeout.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       single-cycle request (accepted in IDLE, DONE, ERR)
//   pathResult  output of path under test, sampled raw on posedge clk
//   pathInput   drive into path under test
//   ld_reg      high while measuring; enables the external delay register
//   fin         measurement complete, delay_count valid
//   timeout     measurement aborted
//   delay_count measured delay in clk cycles
module high_to_low_delay_ctrl #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pathResult,
  output logic             pathInput,
  output logic             ld_reg,
  output logic             fin,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_count
);

  localparam int unsigned SETTLE_W = 8;
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]    TMO_MAX    = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    MEASURE,
    DONE,
    ERR
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [SETTLE_W-1:0] settleCnt;
  logic [SETTLE_W-1:0] settleNext;
  logic [SETTLE_W-1:0] settleInc;
  logic [CNT_W-1:0]    tmoCnt;
  logic [CNT_W-1:0]    tmoNext;
  logic [CNT_W-1:0]    tmoInc;
  logic [CNT_W-1:0]    countNext;
  logic [CNT_W-1:0]    countInc;
  logic                pathInputNext;
  logic                ldRegNext;
  logic                finNext;
  logic                timeoutNext;

  assign settleInc = settleCnt + SETTLE_W'(1);
  assign tmoInc    = tmoCnt + CNT_W'(1);
  assign countInc  = delay_count + CNT_W'(1);

  // State, counters and outputs; outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      settleCnt   <= '0;
      tmoCnt      <= '0;
      delay_count <= '0;
      pathInput   <= 1'b0;
      ld_reg      <= 1'b0;
      fin         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= nextState;
      settleCnt   <= settleNext;
      tmoCnt      <= tmoNext;
      delay_count <= countNext;
      pathInput   <= pathInputNext;
      ld_reg      <= ldRegNext;
      fin         <= finNext;
      timeout     <= timeoutNext;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    nextState  = state;
    settleNext = settleCnt;
    tmoNext    = tmoCnt;
    countNext  = delay_count;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          nextState  = PRECHARGE;
          settleNext = '0;
          tmoNext    = '0;
          countNext  = '0;
        end
      end

      PRECHARGE: begin
        tmoNext    = tmoInc;
        settleNext = pathResult ? settleInc : '0;
        // Settling wins over a coincident precharge timeout
        if (pathResult && (settleInc == SETTLE_MAX)) begin
          nextState  = MEASURE;
          settleNext = '0;
          tmoNext    = '0;
        end else if (tmoInc == TMO_MAX) begin
          nextState = ERR;
        end
      end

      MEASURE: begin
        if (!pathResult) begin
          nextState = DONE;
        end else begin
          countNext = countInc;
          // Abort at the limit so the count saturates instead of wrapping
          if (countInc == TMO_MAX) begin
            nextState = ERR;
          end
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase

    pathInputNext = (nextState == PRECHARGE);
    ldRegNext     = (nextState == MEASURE);
    finNext       = (nextState == DONE);
    timeoutNext   = (nextState == ERR);
  end

endmodule
